// File: rtl/d_mem_axi_pkg.sv
// Shared response codes, FSM state types and sizing helpers for the AXI data memory.
package d_mem_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} r_state_t;

  localparam int DEPTH_WORDS_DEF = 1024;
  localparam int IDX_W_DEF       = $clog2(DEPTH_WORDS_DEF);

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/d_mem_axi_slave_array.sv
// Byte-enabled word array; the registered read port returns same-edge write data so a
// stalled fetch re-read always sees a just-committed word.
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int DATA  = 32,
  parameter int IW    = 10
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IW-1:0]     waddr,
  input  logic [DATA-1:0]   wdata,
  input  logic [DATA/8-1:0] wstrb,
  input  logic              re,
  input  logic [IW-1:0]     raddr,
  output logic [DATA-1:0]   rdata
);

  logic [DATA-1:0] mem [DEPTH];
  logic [DATA-1:0] rd_word;

  always_comb begin
    rd_word = mem[raddr];
    if (we && (waddr == raddr)) begin
      for (int b = 0; b < DATA/8; b++) begin
        if (wstrb[b]) rd_word[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < DATA/8; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= rd_word;
  end

endmodule

// File: rtl/d_mem_axi_slave.sv
// AXI data memory behind the D-cache bridge: single-word strobed writes, full-line reads
// on one wide R beat, independent write/read FSMs sharing one array.
module d_mem_axi_slave
  import d_mem_axi_pkg::*;
#(
  parameter int N_WORD      = 4,
  parameter int DATA        = 32,
  parameter int WIDTH_ADD   = 32,
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic                   AXI_CLK,
  input  logic                   AXI_RESETn,
  input  logic                   AXI_AWVALID,
  output logic                   AXI_AWREADY,
  input  logic [WIDTH_ADD-1:0]   AXI_AWADDR,
  input  logic [2:0]             AXI_AWPROT,
  input  logic [3:0]             AXI_AWCACHE,
  input  logic                   AXI_WVALID,
  output logic                   AXI_WREADY,
  input  logic [DATA-1:0]        AXI_WDATA,
  input  logic [DATA/8-1:0]      AXI_WSTRB,
  output logic                   AXI_BVALID,
  output logic [1:0]             AXI_BRESP,
  input  logic                   AXI_BREADY,
  input  logic                   AXI_ARVALID,
  output logic                   AXI_ARREADY,
  input  logic [WIDTH_ADD-1:0]   AXI_ARADDR,
  input  logic [2:0]             AXI_ARPROT,
  input  logic [3:0]             AXI_ARCACHE,
  output logic                   AXI_RVALID,
  output logic [DATA*N_WORD-1:0] AXI_RDATA,
  output logic [1:0]             AXI_RRESP,
  input  logic                   AXI_RREADY
);

  localparam int IW = idx_width(DEPTH_WORDS);
  localparam int CW = idx_width(N_WORD);
  localparam logic [IW-1:0] LINE_MASK = ~(IW'(N_WORD - 1));

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                    out_of_reset;
  logic                    aw_held, w_held, aw_err;
  logic [IW-1:0]           aw_idx;
  logic [DATA-1:0]         w_data;
  logic [DATA/8-1:0]       w_strb;
  logic                    aw_hs, w_hs, ar_hs, stall;
  logic                    r_err, ar_err_in;
  logic [IW-1:0]           r_base, ar_base_in;
  logic [CW-1:0]           cnt;
  logic [N_WORD-1:0][DATA-1:0] line_buf;
  logic                    mem_we, mem_re;
  logic [IW-1:0]           mem_raddr;
  logic [DATA-1:0]         mem_rdata;
  logic                    unused;

  assign unused = ^{AXI_AWADDR[1:0], AXI_ARADDR[1:0], AXI_AWPROT, AXI_AWCACHE,
                    AXI_ARPROT, AXI_ARCACHE};

  // READY is held low until the first clock edge after reset release.
  assign AXI_AWREADY = out_of_reset && (w_state == W_IDLE) && !aw_held;
  assign AXI_WREADY  = out_of_reset && (w_state == W_IDLE) && !w_held;
  assign AXI_ARREADY = out_of_reset && (r_state == R_IDLE);

  assign aw_hs      = AXI_AWVALID && AXI_AWREADY;
  assign w_hs       = AXI_WVALID && AXI_WREADY;
  assign ar_hs      = AXI_ARVALID && AXI_ARREADY;
  assign stall      = (w_state == W_COMMIT);
  assign ar_err_in  = |AXI_ARADDR[WIDTH_ADD-1:IW+2];
  assign ar_base_in = AXI_ARADDR[IW+1:2] & LINE_MASK;

  always_ff @(posedge AXI_CLK or negedge AXI_RESETn) begin
    if (!AXI_RESETn) begin
      out_of_reset <= 1'b0;
      w_state      <= W_IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= '0;
      aw_err       <= 1'b0;
      w_data       <= '0;
      w_strb       <= '0;
    end else begin
      out_of_reset <= 1'b1;
      w_state      <= w_next;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= AXI_AWADDR[IW+1:2];
        aw_err  <= |AXI_AWADDR[WIDTH_ADD-1:IW+2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= AXI_WDATA;
        w_strb <= AXI_WSTRB;
      end
      if (w_state == W_COMMIT) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next     = w_state;
    AXI_BVALID = 1'b0;
    AXI_BRESP  = RESP_OKAY;
    mem_we     = 1'b0;
    case (w_state)
      W_IDLE:   if ((aw_held || aw_hs) && (w_held || w_hs)) w_next = W_COMMIT;
      W_COMMIT: begin
        mem_we = !aw_err;
        w_next = W_RESP;
      end
      W_RESP: begin
        AXI_BVALID = 1'b1;
        AXI_BRESP  = aw_err ? RESP_SLVERR : RESP_OKAY;
        if (AXI_BREADY) w_next = W_IDLE;
      end
      default:  w_next = W_IDLE;
    endcase
  end

  // The array output is prefetched one word ahead: the AR handshake reads slot 0,
  // each fetch cycle captures slot cnt and reads slot cnt+1 (or re-reads cnt on a stall).
  always_ff @(posedge AXI_CLK or negedge AXI_RESETn) begin
    if (!AXI_RESETn) begin
      r_state  <= R_IDLE;
      r_base   <= '0;
      r_err    <= 1'b0;
      cnt      <= '0;
      line_buf <= '0;
    end else begin
      r_state <= r_next;
      case (r_state)
        R_IDLE: if (ar_hs) begin
          r_base <= ar_base_in;
          r_err  <= ar_err_in;
          cnt    <= '0;
        end
        R_FETCH: if (!stall) begin
          if (!r_err) line_buf[cnt] <= mem_rdata;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    r_next     = r_state;
    AXI_RVALID = 1'b0;
    AXI_RRESP  = RESP_OKAY;
    AXI_RDATA  = '0;
    mem_re     = 1'b0;
    mem_raddr  = ar_base_in;
    case (r_state)
      R_IDLE: begin
        mem_re = ar_hs && !ar_err_in;
        if (ar_hs) r_next = R_FETCH;
      end
      R_FETCH: begin
        mem_re    = !r_err;
        mem_raddr = r_base + IW'(cnt) + (stall ? IW'(0) : IW'(1));
        if (!stall && (cnt == CW'(N_WORD - 1))) r_next = R_RESP;
      end
      R_RESP: begin
        AXI_RVALID = 1'b1;
        if (r_err) AXI_RRESP = RESP_SLVERR;
        else       AXI_RDATA = line_buf;
        if (AXI_RREADY) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  dmem_array #(
    .DEPTH(DEPTH_WORDS),
    .DATA (DATA),
    .IW   (IW)
  ) u_array (
    .clock(AXI_CLK),
    .we   (mem_we),
    .waddr(aw_idx),
    .wdata(w_data),
    .wstrb(w_strb),
    .re   (mem_re),
    .raddr(mem_raddr),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_d_mem_axi_slave.sv
// Directed self-checking bench for d_mem_axi_slave: handshakes, latency, strobes,
// read/write collision, out-of-range responses, backpressure and mid-transaction reset.
module tb_d_mem_axi_slave;

  logic         AXI_CLK = 1'b0;
  logic         AXI_RESETn = 1'b0;
  logic         AXI_AWVALID = 1'b0;
  logic         AXI_AWREADY;
  logic [31:0]  AXI_AWADDR = '0;
  logic [2:0]   AXI_AWPROT = '0;
  logic [3:0]   AXI_AWCACHE = '0;
  logic         AXI_WVALID = 1'b0;
  logic         AXI_WREADY;
  logic [31:0]  AXI_WDATA = '0;
  logic [3:0]   AXI_WSTRB = '0;
  logic         AXI_BVALID;
  logic [1:0]   AXI_BRESP;
  logic         AXI_BREADY = 1'b0;
  logic         AXI_ARVALID = 1'b0;
  logic         AXI_ARREADY;
  logic [31:0]  AXI_ARADDR = '0;
  logic [2:0]   AXI_ARPROT = '0;
  logic [3:0]   AXI_ARCACHE = '0;
  logic         AXI_RVALID;
  logic [127:0] AXI_RDATA;
  logic [1:0]   AXI_RRESP;
  logic         AXI_RREADY = 1'b0;

  int total = 0;
  int bad = 0;

  d_mem_axi_slave #(
    .N_WORD(4), .DATA(32), .WIDTH_ADD(32), .DEPTH_WORDS(1024)
  ) dut (
    .AXI_CLK(AXI_CLK), .AXI_RESETn(AXI_RESETn),
    .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY), .AXI_AWADDR(AXI_AWADDR),
    .AXI_AWPROT(AXI_AWPROT), .AXI_AWCACHE(AXI_AWCACHE),
    .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY), .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB),
    .AXI_BVALID(AXI_BVALID), .AXI_BRESP(AXI_BRESP), .AXI_BREADY(AXI_BREADY),
    .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY), .AXI_ARADDR(AXI_ARADDR),
    .AXI_ARPROT(AXI_ARPROT), .AXI_ARCACHE(AXI_ARCACHE),
    .AXI_RVALID(AXI_RVALID), .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RREADY(AXI_RREADY)
  );

  always #5 AXI_CLK = ~AXI_CLK;

  task automatic tick();
    @(posedge AXI_CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // AW and W presented together; optionally leaves the response pending in W_RESP.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [1:0] exp_resp,
                               input bit accept, input string tag);
    int t = 0;
    AXI_AWVALID = 1'b1; AXI_AWADDR = addr;
    AXI_WVALID  = 1'b1; AXI_WDATA  = data; AXI_WSTRB = strb;
    while (!(AXI_AWREADY && AXI_WREADY) && t < 20) begin tick(); t++; end
    checkOutput({tag, "_ready"}, {127'd0, AXI_AWREADY && AXI_WREADY}, 128'd1);
    tick();
    AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0;
    checkOutput({tag, "_bv_commit"}, {127'd0, AXI_BVALID}, 128'd0);
    tick();
    checkOutput({tag, "_bvalid"}, {127'd0, AXI_BVALID}, 128'd1);
    checkOutput({tag, "_bresp"}, {126'd0, AXI_BRESP}, {126'd0, exp_resp});
    if (accept) begin
      AXI_BREADY = 1'b1;
      tick();
      AXI_BREADY = 1'b0;
    end
  endtask

  task automatic applyRead(input logic [31:0] addr, input int exp_lat, input logic [1:0] exp_resp,
                           input string tag, output logic [127:0] line);
    int t = 0;
    int n = 0;
    AXI_ARVALID = 1'b1; AXI_ARADDR = addr; AXI_RREADY = 1'b1;
    while (!AXI_ARREADY && t < 20) begin tick(); t++; end
    checkOutput({tag, "_arready"}, {127'd0, AXI_ARREADY}, 128'd1);
    tick();
    AXI_ARVALID = 1'b0;
    while (!AXI_RVALID && n < 20) begin tick(); n++; end
    checkOutput({tag, "_lat"}, 128'(n), 128'(exp_lat));
    checkOutput({tag, "_rresp"}, {126'd0, AXI_RRESP}, {126'd0, exp_resp});
    line = AXI_RDATA;
    tick();
    AXI_RREADY = 1'b0;
    checkOutput({tag, "_rv_done"}, {127'd0, AXI_RVALID}, 128'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] line;
    logic [127:0] exp_line;
    int n;

    repeat (3) @(posedge AXI_CLK);
    #1;
    checkOutput("rst_awready", {127'd0, AXI_AWREADY}, 128'd0);
    checkOutput("rst_arready", {127'd0, AXI_ARREADY}, 128'd0);
    checkOutput("rst_bvalid", {127'd0, AXI_BVALID}, 128'd0);
    checkOutput("rst_rvalid", {127'd0, AXI_RVALID}, 128'd0);
    checkOutput("rst_rdata", AXI_RDATA, 128'd0);
    checkOutput("rst_resp", {124'd0, AXI_BRESP, AXI_RRESP}, 128'd0);
    AXI_RESETn = 1'b1;
    checkOutput("rel_wready_pre_edge", {127'd0, AXI_WREADY}, 128'd0);
    tick();
    checkOutput("rel_readies", {125'd0, AXI_AWREADY, AXI_WREADY, AXI_ARREADY}, 128'h7);

    applyStimulus(32'h14, 32'h11111111, 4'hF, 2'b00, 1'b1, "wr14");
    applyStimulus(32'h18, 32'h22222222, 4'hF, 2'b00, 1'b1, "wr18");
    applyStimulus(32'h1C, 32'h33333333, 4'hF, 2'b00, 1'b1, "wr1c");
    applyStimulus(32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 1'b1, "wr10");
    applyRead(32'h10, 4, 2'b00, "rd1", line);
    checkOutput("rd1_line", line, {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF});

    // W three edges ahead of AW, byte 1 only.
    AXI_WVALID = 1'b1; AXI_WDATA = 32'h0000AB00; AXI_WSTRB = 4'b0010;
    tick();
    AXI_WVALID = 1'b0;
    checkOutput("wfirst_wready_held", {127'd0, AXI_WREADY}, 128'd0);
    checkOutput("wfirst_awready", {127'd0, AXI_AWREADY}, 128'd1);
    tick(); tick();
    AXI_AWVALID = 1'b1; AXI_AWADDR = 32'h10;
    tick();
    AXI_AWVALID = 1'b0;
    checkOutput("wfirst_bv_commit", {127'd0, AXI_BVALID}, 128'd0);
    tick();
    checkOutput("wfirst_bvalid", {127'd0, AXI_BVALID}, 128'd1);
    AXI_BREADY = 1'b1;
    tick();
    AXI_BREADY = 1'b0;
    applyRead(32'h10, 4, 2'b00, "rd2", line);
    checkOutput("rd2_line", line, {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADABEF});

    // AR and a write to word 3 of the same line handshake on the same edge.
    AXI_ARVALID = 1'b1; AXI_ARADDR = 32'h10; AXI_RREADY = 1'b1;
    AXI_AWVALID = 1'b1; AXI_AWADDR = 32'h1C; AXI_WVALID = 1'b1;
    AXI_WDATA = 32'h55555555; AXI_WSTRB = 4'hF; AXI_BREADY = 1'b1;
    checkOutput("col_readies", {124'd0, AXI_AWREADY, AXI_WREADY, AXI_ARREADY, 1'b0}, 128'hE);
    tick();
    AXI_ARVALID = 1'b0; AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0;
    n = 0;
    while (!AXI_RVALID && n < 20) begin tick(); n++; end
    checkOutput("col_lat", 128'(n), 128'd5);
    checkOutput("col_line", AXI_RDATA, {32'h55555555, 32'h22222222, 32'h11111111, 32'hDEADABEF});
    tick();
    AXI_RREADY = 1'b0; AXI_BREADY = 1'b0;

    applyStimulus(32'h0, 32'hCAFEF00D, 4'hF, 2'b00, 1'b1, "wr0");
    applyRead(32'h0001_0000, 4, 2'b10, "rd_oor", line);
    checkOutput("rd_oor_rdata", line, 128'd0);
    applyStimulus(32'h0001_0000, 32'h12345678, 4'hF, 2'b10, 1'b1, "wr_oor");
    applyRead(32'h0, 4, 2'b00, "rd0", line);
    checkOutput("rd0_word0", {96'd0, line[31:0]}, {96'd0, 32'hCAFEF00D});

    // Backpressure on R for ten cycles.
    exp_line = {32'h55555555, 32'h22222222, 32'h11111111, 32'hDEADABEF};
    AXI_ARVALID = 1'b1; AXI_ARADDR = 32'h10; AXI_RREADY = 1'b0;
    checkOutput("hold_arready", {127'd0, AXI_ARREADY}, 128'd1);
    tick();
    AXI_ARVALID = 1'b0;
    n = 0;
    while (!AXI_RVALID && n < 20) begin tick(); n++; end
    checkOutput("hold_lat", 128'(n), 128'd4);
    for (int i = 0; i < 10; i++) begin
      checkOutput("hold_rvalid", {127'd0, AXI_RVALID}, 128'd1);
      checkOutput("hold_rdata", AXI_RDATA, exp_line);
      checkOutput("hold_arready_low", {127'd0, AXI_ARREADY}, 128'd0);
      tick();
    end
    AXI_RREADY = 1'b1;
    tick();
    AXI_RREADY = 1'b0;
    checkOutput("hold_release_arready", {127'd0, AXI_ARREADY}, 128'd1);
    checkOutput("hold_release_rvalid", {127'd0, AXI_RVALID}, 128'd0);

    // Reset with a response pending in W_RESP and a read mid-fetch.
    applyStimulus(32'h20, 32'hA5A5A5A5, 4'hF, 2'b00, 1'b0, "wr20");
    AXI_ARVALID = 1'b1; AXI_ARADDR = 32'h10;
    tick();
    AXI_ARVALID = 1'b0;
    tick(); tick();
    checkOutput("prerst_bvalid", {127'd0, AXI_BVALID}, 128'd1);
    AXI_RESETn = 1'b0;
    #1;
    checkOutput("midrst_valids", {126'd0, AXI_BVALID, AXI_RVALID}, 128'd0);
    checkOutput("midrst_readies", {125'd0, AXI_AWREADY, AXI_WREADY, AXI_ARREADY}, 128'd0);
    checkOutput("midrst_rdata", AXI_RDATA, 128'd0);
    tick();
    AXI_RESETn = 1'b1;
    tick();
    applyRead(32'h10, 4, 2'b00, "rd_postrst", line);
    checkOutput("rd_postrst_line", line, exp_line);
    applyRead(32'h20, 4, 2'b00, "rd20", line);
    checkOutput("rd20_word0", {96'd0, line[31:0]}, {96'd0, 32'hA5A5A5A5});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/d_mem_axi_slave.md
# d_mem_axi_slave

AXI slave data memory sitting directly downstream of the D-cache AXI bridge, consuming its write-address/write-data/read-address channels and producing write responses and full cache-line read data. Writes are single 32-bit words with byte strobes; reads return one N_WORD-word line on a single wide R beat. Independent write and read FSMs share one byte-enabled word array, with writes taking priority on collision.

## Interface
- N_WORD, 4, words per cache line returned on R
- DATA, 32, word width in bits
- WIDTH_ADD, 32, AXI address width (byte address)
- DEPTH_WORDS, 1024, array depth in words; power of two, multiple of N_WORD
- AXI_CLK  in  1  clock
- AXI_RESETn  in  1  asynchronous, active-low reset
- AXI_AWVALID / AXI_AWREADY  in / out  1  write-address handshake
- AXI_AWADDR  in  WIDTH_ADD  write byte address
- AXI_AWPROT, AXI_AWCACHE  in  3, 4  accepted, ignored
- AXI_WVALID / AXI_WREADY  in / out  1  write-data handshake
- AXI_WDATA  in  DATA  write word
- AXI_WSTRB  in  DATA/8  byte enables
- AXI_BVALID  out  1  write response valid
- AXI_BRESP  out  2  OKAY 2'b00 / SLVERR 2'b10
- AXI_BREADY  in  1  response accept
- AXI_ARVALID / AXI_ARREADY  in / out  1  read-address handshake
- AXI_ARADDR  in  WIDTH_ADD  read byte address
- AXI_ARPROT, AXI_ARCACHE  in  3, 4  accepted, ignored
- AXI_RVALID  out  1  read line valid
- AXI_RDATA  out  DATA*N_WORD  line; word k at bits [DATA*k +: DATA]
- AXI_RRESP  out  2  OKAY / SLVERR
- AXI_RREADY  in  1  line accept

## Operation
- Word index = addr[log2(DEPTH_WORDS)+1:2]; addr bits above that nonzero = out of range.
- Write FSM W_IDLE, W_COMMIT, W_RESP:
  - W_IDLE: AWREADY = !aw_held, WREADY = !w_held; AW and W latched independently, any order or same cycle.
  - Both held -> W_COMMIT: one cycle, write WDATA under WSTRB (in range only); clear held flags.
  - W_RESP: BVALID=1, BRESP = SLVERR if out of range else OKAY; stay until BREADY -> W_IDLE.
- Read FSM R_IDLE, R_FETCH, R_RESP:
  - R_IDLE: ARREADY=1; on handshake latch line base (ARADDR with low log2(N_WORD)+2 bits cleared), cnt=0 -> R_FETCH.
  - R_FETCH: read word base+cnt per cycle into line buffer slot cnt; cnt increments; after slot N_WORD-1 -> R_RESP.
  - Fetch stalls (cnt holds) in any cycle the write FSM is in W_COMMIT; a word fetched after a commit observes the new data.
  - R_RESP: RVALID=1, RDATA = line buffer, RRESP = SLVERR and RDATA = 0 if out of range; hold until RREADY -> R_IDLE.
- Out-of-range reads skip the array (fetch still runs for fixed latency).
- Array contents are not reset.

## Timing
- Reset: all READY/VALID outputs 0, BRESP/RRESP 2'b00, RDATA 0, FSMs idle, held flags/cnt cleared. AWREADY/WREADY/ARREADY rise the first cycle after reset release.
- Write: last of AW/W handshakes at edge N -> commit edge N+1 -> BVALID from N+1 through BREADY handshake.
- Read: AR handshake edge N -> fetch edges N+1..N+N_WORD (no collisions) -> RVALID from N+N_WORD; each collision adds one cycle.
- VALID/data outputs stable while VALID && !READY.
- Reset mid-transaction: abandon immediately; partially fetched line discarded; a commit not yet clocked does not occur.
- One outstanding write and one outstanding read max; no further AW/W/AR accepted until the respective response handshakes.

## Structure
- Package d_mem_axi_pkg: RESP_OKAY, RESP_SLVERR, write and read state enums, derived index-width constant.
- Sub-module dmem_array: DEPTH_WORDS x DATA, one byte-enabled write port, one read port with registered output.

## Test plan
- AW 0x0000_0010 and W 0xDEADBEEF strobe 4'b1111 same cycle, BREADY=1 -> BVALID 2 cycles later, BRESP 00; AR 0x0000_0010 -> RDATA word0 = 0xDEADBEEF, RVALID at AR+4.
- W before AW by 3 cycles, strobe 4'b0010, data 0x0000AB00 on word 0xDEADBEEF -> word reads 0xDEADABEF.
- Read in R_FETCH of line 0x10 while write 0x5555_5555 to 0x0000_001C commits -> fetch stalls 1 cycle, word3 = 0x55555555, RVALID at AR+5.
- AR 0x0001_0000 (DEPTH_WORDS=1024) -> RRESP 10, RDATA 0; AW same address -> BRESP 10, array unchanged.
- Hold RREADY=0 10 cycles -> RVALID/RDATA stable, ARREADY=0; assert RREADY -> ARREADY next cycle.
- Assert reset during R_FETCH and W_RESP -> all VALIDs 0 immediately; next read returns pre-reset array contents.
